// File: rtl/data_mem_pkg.sv
// Shared encodings and lane helpers for the MEM-stage data memory.
// Helpers work on 64-bit words; callers truncate to DATA_W.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    function automatic logic size_legal(input logic [1:0] size, input logic [2:0] off,
                                        input int data_w);
        logic [2:0] mask;
        mask = 3'((4'd1 << size) - 4'd1);
        if (size == SZ_DWORD && data_w != 64) return 1'b0;
        return (off & mask) == 3'd0;
    endfunction

    function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SZ_BYTE: return 8'h01 << off;
            SZ_HALF: return 8'h03 << off;
            SZ_WORD: return 8'h0f << off;
            default: return 8'hff;
        endcase
    endfunction

    // Store data is copied into every lane so the byte enables alone pick the target bytes.
    function automatic logic [63:0] replicate(input logic [63:0] w, input logic [1:0] size);
        case (size)
            SZ_BYTE: return {8{w[7:0]}};
            SZ_HALF: return {4{w[15:0]}};
            SZ_WORD: return {2{w[31:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] raw, input logic [2:0] off,
                                           input logic [1:0] size, input logic uns);
        logic [63:0] s;
        s = raw >> {off, 3'b000};
        case (size)
            SZ_BYTE: return uns ? {56'd0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
            SZ_HALF: return uns ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
            SZ_WORD: return uns ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_ram.sv
// Byte-lane RAM: one byte array per lane, synchronous write with lane enable
// and synchronous read. No reset on contents.
module byte_lane_ram #(
    parameter int LANES = 4,
    parameter int AW    = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic               re,
    input  logic [LANES-1:0]   be,
    input  logic [AW-1:0]      addr,
    input  logic [LANES*8-1:0] wdata,
    output logic [LANES*8-1:0] rdata
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] mem [2**AW];
        logic [7:0] rd;
        always_ff @(posedge clk) begin
            if (we && be[i]) mem[addr] <= wdata[i*8 +: 8];
            if (re)          rd        <= mem[addr];
        end
        assign rdata[i*8 +: 8] = rd;
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: one outstanding request, fixed read latency,
// alignment checking, sign/zero-extended loads and a saturating error counter.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int WA_W  = ADDR_W - OFF_W;

    state_t      state;
    logic [1:0]  cnt;
    logic        accept, legal, ram_we, ram_re;
    logic [2:0]  off;
    logic [LANES-1:0]  be;
    logic [DATA_W-1:0] wdata, ram_rdata, raw, ext;

    logic       op_err, op_write, op_uns;
    logic [1:0] op_size;
    logic [2:0] op_off;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign off       = 3'(req_addr[OFF_W-1:0]);
    assign legal     = size_legal(req_size, off, DATA_W);
    // Illegal requests never touch the array, reads included.
    assign ram_we    = accept && req_write && legal;
    assign ram_re    = accept && !req_write && legal;
    assign be        = LANES'(byte_en(req_size, off));
    assign wdata     = DATA_W'(replicate(64'(req_wdata), req_size));

    byte_lane_ram #(.LANES(LANES), .AW(WA_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .be    (be),
        .addr  (req_addr[ADDR_W-1:OFF_W]),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    // The RAM holds its output between reads, so the delay line needs no enable.
    if (READ_LAT == 1) begin : g_nopipe
        assign raw = ram_rdata;
    end else begin : g_pipe
        logic [DATA_W-1:0] stg [READ_LAT-1];
        always_ff @(posedge clk) begin
            stg[0] <= ram_rdata;
            for (int k = 1; k < READ_LAT - 1; k++) stg[k] <= stg[k-1];
        end
        assign raw = stg[READ_LAT-2];
    end

    assign ext = DATA_W'(extend(64'(raw), op_off, op_size, op_uns));

    // RESP is entered one cycle before rsp_valid rises; that first RESP cycle loads the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            err_count <= '0;
            op_err    <= 1'b0;
            op_write  <= 1'b0;
            op_uns    <= 1'b0;
            op_size   <= SZ_BYTE;
            op_off    <= 3'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_err   <= !legal;
                    op_write <= req_write;
                    op_uns   <= req_unsigned;
                    op_size  <= req_size;
                    op_off   <= off;
                    cnt      <= 2'd0;
                    state    <= (READ_LAT == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    if (cnt == 2'(READ_LAT - 2)) state <= RESP;
                    else                         cnt   <= cnt + 2'd1;
                end
                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= op_err;
                        rsp_rdata <= (op_err || op_write) ? '0 : ext;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                        if (rsp_err && err_count != '1) err_count <= err_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized bench for data_mem_ctrl against a byte-array reference model,
// plus directed alignment, stall, reset and latency cases.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned, rsp_valid, rsp_ready, rsp_err;
    logic [1:0]  req_size;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata, rsp_rdata;
    logic [7:0]  err_count;

    logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [1:0]  b_req_size;
    logic [9:0]  b_req_addr;
    logic [31:0] b_req_wdata, b_rsp_rdata;
    logic [7:0]  b_err_count;

    int checks = 0;
    int failures = 0;
    logic [7:0] mem_m [1024];
    int mdl_err = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DATA_W(32), .ADDR_W(10), .READ_LAT(1), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .err_count(err_count)
    );

    data_mem_ctrl #(.DATA_W(32), .ADDR_W(10), .READ_LAT(3), .ERR_CNT_W(8)) dut_lat3 (
        .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
        .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .err_count(b_err_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit mdl_legal(input logic [1:0] sz, input logic [9:0] a);
        return (sz != 2'd3) && ((int'(a) % (1 << sz)) == 0);
    endfunction

    // Little-endian byte gather, then extend from bit 8*n-1.
    function automatic logic [31:0] mdl_load(input logic [9:0] a, input logic [1:0] sz, input bit uns);
        logic [63:0] v;
        int n;
        v = 64'd0;
        n = 1 << sz;
        for (int i = 0; i < n; i++) v = v | (64'(mem_m[int'(a) + i]) << (8 * i));
        if (!uns && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic mdl_store(input logic [1:0] sz, input logic [9:0] a, input logic [31:0] wd);
        for (int i = 0; i < (1 << sz); i++) mem_m[int'(a) + i] = wd[8*i +: 8];
    endtask

    task automatic op(input bit wr, input logic [1:0] sz, input bit uns, input logic [9:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int lat;
        bit legal;
        logic [31:0] exp_rd;
        legal  = mdl_legal(sz, a);
        exp_rd = (legal && !wr) ? mdl_load(a, sz, uns) : 32'd0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        lat = 0;
        while (!req_ready && lat < 20) begin @(negedge clk); lat++; end
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (legal && wr) mdl_store(sz, a, wd);
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, 1);
        rd = rsp_rdata;
        er = rsp_err;
        chk("rsp_err", er, !legal);
        chk("rsp_rdata", rd, exp_rd);
        @(posedge clk); #1;
        if (!legal && mdl_err < 255) mdl_err++;
        chk("err_count", err_count, mdl_err);
        chk("rsp_valid_drop", rsp_valid, 0);
        chk("req_ready_back", req_ready, 1);
    endtask

    task automatic b_op(input bit wr, input logic [9:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output int lat);
        @(negedge clk);
        b_req_valid = 1'b1; b_req_write = wr; b_req_size = 2'd2; b_req_addr = a; b_req_wdata = wd;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        lat = 0;
        while (!b_rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rd = b_rsp_rdata;
        @(posedge clk); #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, cap;
        logic er, cap_err;
        int lat;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_size = 2'd0; b_req_unsigned = 1'b0;
        b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err_count", err_count, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 64; i += 4) op(1, 2'd2, 0, 10'(i), $urandom, rd, er);

        op(1, 2'd2, 0, 10'h28, 32'hDEADBEEF, rd, er);
        op(0, 2'd2, 0, 10'h28, 0, rd, er);
        chk("t2_word", rd, 32'hDEADBEEF);
        op(0, 2'd0, 0, 10'h2B, 0, rd, er);
        chk("t3_byte_s", rd, 32'hFFFFFFDE);
        op(0, 2'd0, 1, 10'h2B, 0, rd, er);
        chk("t3_byte_u", rd, 32'h000000DE);
        op(0, 2'd1, 0, 10'h2A, 0, rd, er);
        chk("t3_half_s", rd, 32'hFFFFDEAD);
        op(1, 2'd0, 0, 10'h29, 32'h55, rd, er);
        op(0, 2'd2, 0, 10'h28, 0, rd, er);
        chk("t4_merge", rd, 32'hDEAD55EF);
        op(1, 2'd2, 0, 10'h2A, 32'h12345678, rd, er);
        chk("t5_mis_err", er, 1);
        chk("t5_errcnt1", err_count, 1);
        op(0, 2'd2, 0, 10'h28, 0, rd, er);
        chk("t5_nowrite", rd, 32'hDEAD55EF);
        op(0, 2'd3, 0, 10'h28, 0, rd, er);
        chk("t5_dword_err", er, 1);
        chk("t5_errcnt2", err_count, 2);

        // Response back-pressure.
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 10'h28;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        cap = rsp_rdata;
        cap_err = rsp_err;
        chk("t6_rdata", cap, 32'hDEAD55EF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t6_valid_hold", rsp_valid, 1);
            chk("t6_rdata_hold", rsp_rdata, cap);
            chk("t6_err_hold", rsp_err, cap_err);
            chk("t6_req_ready_low", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("t6_valid_drop", rsp_valid, 0);
        chk("t6_req_ready_up", req_ready, 1);

        for (int i = 0; i < 300; i++)
            op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               10'($urandom_range(0, 63)), $urandom, rd, er);

        while (mdl_err < 255) op(0, 2'd3, 0, 10'h00, 0, rd, er);
        op(1, 2'd1, 0, 10'h01, 32'hFFFF, rd, er);
        chk("sat_errcnt", err_count, 8'hFF);

        // Reset with an errored response pending.
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 10'h29;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("midrst_pre_err", rsp_err, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_err", rsp_err, 0);
        chk("midrst_errcnt", err_count, 0);
        chk("midrst_req_ready", req_ready, 1);
        mdl_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // Reset right after a store is accepted keeps the write.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 10'h30; req_wdata = 32'hA5A51234;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        mdl_store(2'd2, 10'h30, 32'hA5A51234);
        #1;
        chk("strst_req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        op(0, 2'd2, 0, 10'h30, 0, rd, er);
        chk("strst_kept", rd, 32'hA5A51234);

        b_op(1, 10'h10, 32'hCAFEF00D, rd, lat);
        chk("lat3_store", lat, 3);
        b_op(0, 10'h10, 0, rd, lat);
        chk("lat3_load", lat, 3);
        chk("lat3_rdata", rd, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
